ex_mem_pipe_stage: RTL and testbench

Parametrised, elastic EX→MEM pipeline stage: the successor to the fixed EX/MEM register. It carries ALU result, store data, destination register, memory/writeback controls and branch resolution from execute to memory access. It adds valid/ready flow control, synchronous flush and an optional 2-entry skid buffer, so that memory-side stalls back-pressure execute without bubbles and without a combinational ready path. Payload widths are parameters.

---
 rtl/ex_mem_pipe_stage.sv | 198 +++++++++++++++++++
 tb/tb_ex_mem_pipe_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_stage
//
// Elastic EX->MEM pipeline stage. It carries the ALU result, store data,
// destination register, memory/writeback controls and branch resolution from
// execute to memory access. Flow control is valid/ready on both sides. A
// synchronous flush discards every held entry and any entry offered in the
// same cycle.
//
// Optional feature macro: EX_MEM_SKID_EN
//   defined   : main register plus one skid register (states EMPTY/ONE/TWO).
//               in_ready comes straight from the state register, so there is
//               no combinational out_ready -> in_ready path.
//   undefined : single register (states EMPTY/ONE).
//               in_ready = !out_valid || out_ready.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               synchronous kill of held and incoming entries
//   in_valid / in_ready execute-side handshake
//   in_*                payload from execute (branch target is TGT_IN_W wide)
//   out_valid/out_ready memory-side handshake
//   out_*               registered payload; out_reg_write, out_mem_write,
//                       out_mem_read and out_branch_taken read 0 while
//                       out_valid is low, the rest hold their last value
// ---------------------------------------------------------------------------
module ex_mem_pipe_stage #(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 5,
   parameter int TGT_IN_W  = 32,
   parameter int TGT_OUT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_reg_write,
   input  logic                 in_mem_to_reg,
   input  logic                 in_mem_write,
   input  logic                 in_mem_read,
   input  logic [DATA_W-1:0]    in_alu_result,
   input  logic [DATA_W-1:0]    in_write_data,
   input  logic [REG_AW-1:0]    in_write_reg,
   input  logic                 in_branch_taken,
   input  logic [TGT_IN_W-1:0]  in_branch_target,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_reg_write,
   output logic                 out_mem_to_reg,
   output logic                 out_mem_write,
   output logic                 out_mem_read,
   output logic                 out_branch_taken,
   output logic [DATA_W-1:0]    out_alu_result,
   output logic [DATA_W-1:0]    out_write_data,
   output logic [REG_AW-1:0]    out_write_reg,
   output logic [TGT_OUT_W-1:0] out_branch_target
);

   typedef struct packed {
      logic                 reg_write;
      logic                 mem_to_reg;
      logic                 mem_write;
      logic                 mem_read;
      logic                 branch_taken;
      logic [DATA_W-1:0]    alu_result;
      logic [DATA_W-1:0]    write_data;
      logic [REG_AW-1:0]    write_reg;
      logic [TGT_OUT_W-1:0] branch_target;
   } entry_t;

`ifdef EX_MEM_SKID_EN
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
   typedef enum logic {EMPTY = 1'b0, ONE = 1'b1} state_t;
`endif

   state_t state, state_next;
   entry_t in_entry;
   entry_t main_p0;
   logic   in_xfer, out_xfer;
   logic   load_main;
   logic   unused_tgt;
`ifdef EX_MEM_SKID_EN
   entry_t skid_p0;
   logic   load_skid, skid_to_main;
`endif

   // Only the low TGT_OUT_W bits of the branch target travel onward.
   assign unused_tgt = ^in_branch_target;

   always_comb begin
      in_entry               = '0;
      in_entry.reg_write     = in_reg_write;
      in_entry.mem_to_reg    = in_mem_to_reg;
      in_entry.mem_write     = in_mem_write;
      in_entry.mem_read      = in_mem_read;
      in_entry.branch_taken  = in_branch_taken;
      in_entry.alu_result    = in_alu_result;
      in_entry.write_data    = in_write_data;
      in_entry.write_reg     = in_write_reg;
      in_entry.branch_target = in_branch_target[TGT_OUT_W-1:0];
   end

   assign out_valid = (state != EMPTY);
`ifdef EX_MEM_SKID_EN
   assign in_ready  = (state != TWO);
`else
   assign in_ready  = !out_valid || out_ready;
`endif
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      state_next = state;
      load_main  = 1'b0;
`ifdef EX_MEM_SKID_EN
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
`endif
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               state_next = ONE;
               load_main  = 1'b1;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               load_main = 1'b1;
            end else if (out_xfer) begin
               state_next = EMPTY;
`ifdef EX_MEM_SKID_EN
            end else if (in_xfer) begin
               // Consumer stalled: park the newcomer behind the head entry.
               state_next = TWO;
               load_skid  = 1'b1;
`endif
            end
         end
`ifdef EX_MEM_SKID_EN
         TWO: begin
            if (out_xfer) begin
               state_next   = ONE;
               skid_to_main = 1'b1;
            end
         end
`endif
         default: state_next = EMPTY;
      endcase
      // Flush wins over every transfer; register contents are left alone.
      if (flush) begin
         state_next = EMPTY;
         load_main  = 1'b0;
`ifdef EX_MEM_SKID_EN
         load_skid    = 1'b0;
         skid_to_main = 1'b0;
`endif
      end
   end

   // Stage p0: state and main register (outputs read zero after reset)
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= EMPTY;
         main_p0 <= '0;
      end else begin
         state <= state_next;
         if (load_main) begin
            main_p0 <= in_entry;
`ifdef EX_MEM_SKID_EN
         end else if (skid_to_main) begin
            main_p0 <= skid_p0;
`endif
         end
      end
   end

`ifdef EX_MEM_SKID_EN
   // Stage p0: skid register, only meaningful while state is TWO
   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_p0 <= in_entry;
      end
   end
`endif

   assign out_reg_write     = out_valid & main_p0.reg_write;
   assign out_mem_to_reg    = main_p0.mem_to_reg;
   assign out_mem_write     = out_valid & main_p0.mem_write;
   assign out_mem_read      = out_valid & main_p0.mem_read;
   assign out_branch_taken  = out_valid & main_p0.branch_taken;
   assign out_alu_result    = main_p0.alu_result;
   assign out_write_data    = main_p0.write_data;
   assign out_write_reg     = main_p0.write_reg;
   assign out_branch_target = main_p0.branch_target;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_pipe_stage
//
// Directed and random stimulus for ex_mem_pipe_stage. A queue holds the
// entries the stage should currently contain; every cycle the full output
// bundle is compared against the head of that queue. Skid-specific steps are
// built when EX_MEM_SKID_EN is defined, single-register steps otherwise.
// ---------------------------------------------------------------------------
module tb_ex_mem_pipe_stage;
   localparam int DATA_W    = 32;
   localparam int REG_AW    = 5;
   localparam int TGT_IN_W  = 32;
   localparam int TGT_OUT_W = 8;

   logic                 clk = 1'b0;
   logic                 reset, flush, in_valid, in_ready;
   logic                 in_reg_write, in_mem_to_reg, in_mem_write, in_mem_read;
   logic [DATA_W-1:0]    in_alu_result, in_write_data;
   logic [REG_AW-1:0]    in_write_reg;
   logic                 in_branch_taken;
   logic [TGT_IN_W-1:0]  in_branch_target;
   logic                 out_valid, out_ready;
   logic                 out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read;
   logic                 out_branch_taken;
   logic [DATA_W-1:0]    out_alu_result, out_write_data;
   logic [REG_AW-1:0]    out_write_reg;
   logic [TGT_OUT_W-1:0] out_branch_target;

   always #5 clk = ~clk;

   ex_mem_pipe_stage #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .TGT_IN_W(TGT_IN_W), .TGT_OUT_W(TGT_OUT_W)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
      .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
      .in_alu_result(in_alu_result), .in_write_data(in_write_data),
      .in_write_reg(in_write_reg), .in_branch_taken(in_branch_taken),
      .in_branch_target(in_branch_target),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
      .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
      .out_branch_taken(out_branch_taken),
      .out_alu_result(out_alu_result), .out_write_data(out_write_data),
      .out_write_reg(out_write_reg), .out_branch_target(out_branch_target)
   );

   typedef struct packed {
      logic        rw, m2r, mw, mr, bt;
      logic [31:0] alu, wd;
      logic [4:0]  wr;
      logic [7:0]  tgt;
   } ent_t;

   ent_t q[$];
   ent_t last_head = '0;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_ready();
`ifdef EX_MEM_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || (out_ready == 1'b1);
`endif
   endfunction

   function automatic ent_t cur_in();
      ent_t e;
      logic [31:0] t;
      t     = in_branch_target;
      e.rw  = in_reg_write;
      e.m2r = in_mem_to_reg;
      e.mw  = in_mem_write;
      e.mr  = in_mem_read;
      e.bt  = in_branch_taken;
      e.alu = in_alu_result;
      e.wd  = in_write_data;
      e.wr  = in_write_reg;
      e.tgt = t[7:0];
      return e;
   endfunction

   function automatic logic [127:0] obs_vec();
      return {44'd0, in_ready, out_valid, out_reg_write, out_mem_to_reg, out_mem_write,
              out_mem_read, out_branch_taken, out_alu_result, out_write_data,
              out_write_reg, out_branch_target};
   endfunction

   function automatic logic [127:0] exp_vec();
      logic v;
      ent_t h;
      v = (q.size() > 0);
      h = last_head;
      return {44'd0, model_ready(), v, v & h.rw, h.m2r, v & h.mw, v & h.mr, v & h.bt,
              h.alu, h.wd, h.wr, h.tgt};
   endfunction

   // One clock: update the model from the inputs seen at the edge, then
   // compare the whole output bundle shortly after the edge.
   task automatic step(input string tag);
      bit   ix, ox;
      ent_t e;
      ix = (in_valid == 1'b1) && model_ready();
      ox = (q.size() > 0) && (out_ready == 1'b1);
      e  = cur_in();
      @(posedge clk);
      if (reset) begin
         q.delete();
         last_head = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (ox) void'(q.pop_front());
         if (ix) q.push_back(e);
      end
      if (q.size() > 0) last_head = q[0];
      #1;
      check(tag, obs_vec(), exp_vec());
   endtask

   task automatic drive(input logic v, input logic [31:0] alu);
      in_valid         = v;
      in_reg_write     = 1'($urandom_range(0, 1));
      in_mem_to_reg    = 1'($urandom_range(0, 1));
      in_mem_write     = 1'($urandom_range(0, 1));
      in_mem_read      = 1'($urandom_range(0, 1));
      in_branch_taken  = 1'($urandom_range(0, 1));
      in_alu_result    = alu;
      in_write_data    = $urandom;
      in_write_reg     = 5'($urandom_range(0, 31));
      in_branch_target = $urandom;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(1'b1, 32'h5555_0000);

      // Reset held two cycles with in_valid high
      step("reset0");
      step("reset1");
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_outputs", {out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read,
            out_branch_taken, out_alu_result, out_write_data, out_write_reg,
            out_branch_target}, 128'd0);
      reset = 1'b0;
      in_valid = 1'b0;
      step("idle");

      // Streaming 1..8 with out_ready high: one per cycle, one-cycle latency
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 32'(k));
         step("stream");
         check("stream_alu", 128'(out_alu_result), 128'(k));
         check("stream_valid", 128'(out_valid), 128'd1);
      end
      in_valid = 1'b0;
      step("stream_drain");
      check("stream_empty", 128'(out_valid), 128'd0);

      // Branch target truncation
      drive(1'b1, 32'h0000_0077);
      in_branch_target = 32'h1234_56AB;
      in_branch_taken  = 1'b1;
      step("tgt");
      check("tgt_trunc", 128'(out_branch_target), 128'h0AB);
      check("tgt_taken", 128'(out_branch_taken), 128'd1);
      in_valid = 1'b0;
      step("tgt_drain");

`ifdef EX_MEM_SKID_EN
      // Back-pressure: A and B accepted, C waits until release
      out_ready = 1'b0;
      drive(1'b1, 32'hA);
      step("bp_a");
      check("bp_a_out", 128'(out_alu_result), 128'hA);
      drive(1'b1, 32'hB);
      step("bp_b");
      check("bp_b_ready", 128'(in_ready), 128'd0);
      check("bp_b_hold", 128'(out_alu_result), 128'hA);
      drive(1'b1, 32'hC);
      step("bp_c");
      check("bp_c_hold", 128'(out_alu_result), 128'hA);
      out_ready = 1'b1;
      step("bp_rel1");
      check("bp_rel1_out", 128'(out_alu_result), 128'hB);
      step("bp_rel2");
      check("bp_rel2_out", 128'(out_alu_result), 128'hC);
      in_valid = 1'b0;
      step("bp_drain");
      check("bp_empty", 128'(out_valid), 128'd0);

      // Flush while TWO with a new entry offered
      out_ready = 1'b0;
      drive(1'b1, 32'h11); in_mem_write = 1'b1;
      step("fl_fill1");
      drive(1'b1, 32'h22); in_mem_write = 1'b1;
      step("fl_fill2");
      drive(1'b1, 32'hDEAD); in_mem_write = 1'b1;
      flush = 1'b1;
      step("fl_flush");
      check("fl_valid", 128'(out_valid), 128'd0);
      check("fl_mem_write", 128'(out_mem_write), 128'd0);
      check("fl_ready", 128'(in_ready), 128'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step("fl_after");
      check("fl_gone", 128'(out_valid), 128'd0);
`else
      // Single register: stall and release propagate to in_ready at once
      out_ready = 1'b0;
      drive(1'b1, 32'h33);
      step("ns_load");
      in_valid = 1'b0;
      #1;
      check("ns_stall_ready", 128'(in_ready), 128'd0);
      out_ready = 1'b1;
      #1;
      check("ns_release_ready", 128'(in_ready), 128'd1);
      step("ns_drain");
      check("ns_empty", 128'(out_valid), 128'd0);

      // Flush while holding an entry with a new one offered
      out_ready = 1'b0;
      drive(1'b1, 32'h44); in_mem_write = 1'b1;
      step("fl_fill");
      out_ready = 1'b1;
      drive(1'b1, 32'hDEAD); in_mem_write = 1'b1;
      flush = 1'b1;
      step("fl_flush");
      check("fl_valid", 128'(out_valid), 128'd0);
      check("fl_mem_write", 128'(out_mem_write), 128'd0);
      check("fl_ready", 128'(in_ready), 128'd1);
      flush = 1'b0; in_valid = 1'b0;
      step("fl_after");
      check("fl_gone", 128'(out_valid), 128'd0);
`endif

      // Reset in the middle of traffic drops held entries
      out_ready = 1'b0;
      drive(1'b1, 32'h66);
      step("mid_fill");
      reset = 1'b1;
      step("mid_reset");
      check("mid_rst_valid", 128'(out_valid), 128'd0);
      check("mid_rst_alu", 128'(out_alu_result), 128'd0);
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step("mid_idle");

      // Random traffic against the queue model
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom);
         out_ready = 1'($urandom_range(0, 2) != 0);
         flush     = 1'($urandom_range(0, 19) == 0);
         reset     = 1'($urandom_range(0, 49) == 0);
         step("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
